muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit for the execute stage, next to the single-cycle ALU.

---
 rtl/muldiv_unit_if.sv | 38 +++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
//   slave  : the unit (consumes requests, produces results)
//   master : the execute stage driving requests and taking results
// Signals:
//   valid_i/ready_o     request handshake
//   funct3_i            RV32M op select
//   rs1_i/rs2_i/tag_i   operands and pass-through tag
//   flush_i             kill any in-flight op
//   valid_o/ready_i     result handshake
//   res_o/tag_o         result and its tag
//   busy_o              unit not idle
interface muldiv_unit_if #(
    parameter int DWIDTH = 32,
    parameter int TAGW   = 5
);
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        funct3_i;
    logic [DWIDTH-1:0] rs1_i;
    logic [DWIDTH-1:0] rs2_i;
    logic [TAGW-1:0]   tag_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [DWIDTH-1:0] res_o;
    logic [TAGW-1:0]   tag_o;
    logic              busy_o;

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, res_o, tag_o, busy_o
    );

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, res_o, tag_o, busy_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2, one step per cycle).
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : muldiv_unit_if.slave, request/result handshakes, flush, busy
// Ops by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM, 111 REMU.
// Divide by zero and signed overflow complete directly from IDLE.
module muldiv_unit #(
    parameter int DWIDTH = 32,
    parameter int TAGW   = 5
) (
    input logic           clk,
    input logic           rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(DWIDTH + 1);
    localparam logic [DWIDTH-1:0] MIN_INT = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg;
    logic [CW-1:0]       count_reg;
    logic [2:0]          op_reg;
    logic [DWIDTH-1:0]   a_reg;       // multiplicand magnitude
    logic [DWIDTH-1:0]   b_reg;       // divisor magnitude
    logic [2*DWIDTH-1:0] acc_reg;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic                qneg_reg;    // negate product / quotient at the end
    logic                rneg_reg;    // negate remainder at the end
    logic [DWIDTH-1:0]   res_reg;
    logic [TAGW-1:0]     tag_reg;

    // Request decode
    logic              sign_a, sign_b, div_zero, div_ovf;
    logic [DWIDTH-1:0] mag_a, mag_b;

    always_comb begin
        if (bus.funct3_i[2]) begin
            sign_a = ~bus.funct3_i[0] & bus.rs1_i[DWIDTH-1];
            sign_b = ~bus.funct3_i[0] & bus.rs2_i[DWIDTH-1];
        end else begin
            sign_a = ((bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010)) & bus.rs1_i[DWIDTH-1];
            sign_b = (bus.funct3_i == 3'b001) & bus.rs2_i[DWIDTH-1];
        end
        mag_a    = sign_a ? -bus.rs1_i : bus.rs1_i;
        mag_b    = sign_b ? -bus.rs2_i : bus.rs2_i;
        div_zero = (bus.rs2_i == '0);
        div_ovf  = ~bus.funct3_i[0] & (bus.rs1_i == MIN_INT) & (bus.rs2_i == '1);
    end

    // One iteration of the datapath plus final sign fix and result select
    logic [DWIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*DWIDTH-1:0] acc_step, prod_fix;
    logic [DWIDTH-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*DWIDTH-1:DWIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
        div_shift = {acc_reg[2*DWIDTH-1:DWIDTH], acc_reg[DWIDTH-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        if (op_reg[2]) begin
            // Top bit of the difference is the borrow: set means "restore"
            if (!div_diff[DWIDTH])
                acc_step = {div_diff[DWIDTH-1:0], acc_reg[DWIDTH-2:0], 1'b1};
            else
                acc_step = {div_shift[DWIDTH-1:0], acc_reg[DWIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_reg[DWIDTH-1:1]};
        end
        prod_fix = qneg_reg ? -acc_step : acc_step;
        quo_fix  = qneg_reg ? -acc_step[DWIDTH-1:0] : acc_step[DWIDTH-1:0];
        rem_fix  = rneg_reg ? -acc_step[2*DWIDTH-1:DWIDTH] : acc_step[2*DWIDTH-1:DWIDTH];
        case (op_reg)
            3'b000:                 final_res = prod_fix[DWIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*DWIDTH-1:DWIDTH];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            res_reg   <= '0;
            tag_reg   <= '0;
        end else if (bus.flush_i) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: if (bus.valid_i) begin
                    op_reg    <= bus.funct3_i;
                    tag_reg   <= bus.tag_i;
                    count_reg <= CW'(DWIDTH);
                    a_reg     <= mag_a;
                    b_reg     <= mag_b;
                    qneg_reg  <= sign_a ^ sign_b;
                    rneg_reg  <= sign_a;
                    if (!bus.funct3_i[2]) begin
                        acc_reg   <= {{DWIDTH{1'b0}}, mag_b};
                        state_reg <= CALC;
                    end else if (div_zero) begin
                        res_reg   <= bus.funct3_i[1] ? bus.rs1_i : '1;
                        state_reg <= DONE;
                    end else if (div_ovf) begin
                        res_reg   <= bus.funct3_i[1] ? '0 : MIN_INT;
                        state_reg <= DONE;
                    end else begin
                        acc_reg   <= {{DWIDTH{1'b0}}, mag_a};
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg   <= acc_step;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        res_reg   <= final_res;
                        state_reg <= DONE;
                    end
                end
                DONE: if (bus.ready_i) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready_o = (state_reg == IDLE) & ~rst;
    assign bus.busy_o  = (state_reg != IDLE) & ~rst;
    assign bus.valid_o = (state_reg == DONE);
    assign bus.res_o   = res_reg;
    assign bus.tag_o   = tag_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.DWIDTH(32), .TAGW(5)) bus();
    muldiv_unit #(.DWIDTH(32), .TAGW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        int          edges;   // edges after the accept edge until valid_o is seen
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Count edges after the current point until valid_o is seen (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.valid_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic drive(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.valid_i  = 1'b1;
        bus.funct3_i = fn;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.tag_i    = tag;
    endtask

    initial begin
        int n;
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        int valid_seen;

        vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 32};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 32};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 32};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF, 32};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD, 32};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFF, 32};
        vecs[6]  = '{3'b101, 32'hFFFFFFFE, 32'h00000002, 5'd6,  32'h7FFFFFFF, 32};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd7,  32'd2,        32};
        vecs[8]  = '{3'b100, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 0};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        5'd10, 32'd5,        0};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        0};
        vecs[12] = '{3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 0};
        vecs[13] = '{3'b000, 32'h12345678, 32'h00000010, 5'd14, 32'h23456780, 32};
        vecs[14] = '{3'b001, 32'hFFFFFFFF, 32'h00000003, 5'd15, 32'hFFFFFFFF, 32};
        vecs[15] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        32};
        vecs[16] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 32};

        rst = 1'b1;
        bus.valid_i = 1'b0; bus.funct3_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
        bus.tag_i = '0; bus.flush_i = 1'b0; bus.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready_o", 32'(bus.ready_o), 32'd0);
        chk("reset busy_o",  32'(bus.busy_o),  32'd0);
        chk("reset valid_o", 32'(bus.valid_o), 32'd0);
        chk("reset res_o",   bus.res_o,        32'd0);
        chk("reset tag_o",   32'(bus.tag_o),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven ops
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("v%0d ready_o", i), 32'(bus.ready_o), 32'd1);
            drive(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag);
            @(posedge clk); #1;           // accept edge E0
            bus.valid_i = 1'b0;
            wait_valid(n);
            chk($sformatf("v%0d latency", i), 32'(n), 32'(vecs[i].edges));
            chk($sformatf("v%0d res", i), bus.res_o, vecs[i].res);
            chk($sformatf("v%0d tag", i), 32'(bus.tag_o), 32'(vecs[i].tag));
            $display("op fn=%b a=%h b=%h -> res=%h tag=%0d edges=%0d", vecs[i].fn, vecs[i].a, vecs[i].b, bus.res_o, bus.tag_o, n);
            bus.ready_i = 1'b1;
            @(posedge clk); #1;
            bus.ready_i = 1'b0;
            chk($sformatf("v%0d valid_o drop", i), 32'(bus.valid_o), 32'd0);
        end

        // Backpressure: results held, new requests ignored, then back-to-back accept
        drive(3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd9);
        @(posedge clk); #1;
        chk("bp busy during calc", 32'(bus.busy_o), 32'd1);
        drive(3'b101, 32'd100, 32'd7, 5'd3);  // stays asserted throughout
        wait_valid(n);
        chk("bp latency", 32'(n), 32'd32);
        held_res = bus.res_o;
        held_tag = bus.tag_o;
        chk("bp res", held_res, 32'hFFFFFFEB);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d res", k), bus.res_o, 32'hFFFFFFEB);
            chk($sformatf("bp hold%0d tag", k), 32'(bus.tag_o), 32'd9);
            chk($sformatf("bp hold%0d ready_o", k), 32'(bus.ready_o), 32'd0);
            chk($sformatf("bp hold%0d valid_o", k), 32'(bus.valid_o), 32'd1);
        end
        $display("backpressure held res=%h tag=%0d", bus.res_o, bus.tag_o);
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        chk("bp release ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;               // queued DIVU accepted here
        bus.valid_i = 1'b0;
        wait_valid(n);
        chk("b2b latency", 32'(n), 32'd32);
        chk("b2b res", bus.res_o, 32'd14);
        chk("b2b tag", 32'(bus.tag_o), 32'd3);
        $display("back-to-back DIVU 100/7 -> res=%h tag=%0d", bus.res_o, bus.tag_o);
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;

        // Flush in the 5th CALC cycle
        drive(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
        @(posedge clk); #1;               // E0
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("flush ready_o", 32'(bus.ready_o), 32'd1);
        chk("flush busy_o",  32'(bus.busy_o),  32'd0);
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid_o === 1'b1) valid_seen++;
            @(posedge clk); #1;
        end
        chk("flush valid_o never", 32'(valid_seen), 32'd0);
        $display("flush in calc -> valid_o seen %0d times", valid_seen);

        // Reset in the 5th CALC cycle
        drive(3'b000, 32'h00000003, 32'h00000005, 5'd22);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst ready_o", 32'(bus.ready_o), 32'd0);
        chk("rst busy_o",  32'(bus.busy_o),  32'd0);
        chk("rst valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst res_o",   bus.res_o,        32'd0);
        chk("rst tag_o",   32'(bus.tag_o),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst release ready_o", 32'(bus.ready_o), 32'd1);
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid_o === 1'b1) valid_seen++;
            @(posedge clk); #1;
        end
        chk("rst valid_o never", 32'(valid_seen), 32'd0);
        $display("reset in calc -> res=%h tag=%0d valid seen %0d", bus.res_o, bus.tag_o, valid_seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
